// File: rtl/spi_burst_pkg.sv
// rtl/spi_burst_pkg.sv - shared widths, defaults and FSM encoding for the SPI burst sequencer
package spi_burst_pkg;

    localparam int DATA_W      = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 1024;
    localparam int LEN_W       = 5;

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LVL_W = lvl_width(DEF_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_DONE,
        ST_ABORT
    } state_t;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// rtl/spi_burst_ctrl_if.sv - host-side and SPI-master-side signal bundle of the burst sequencer
interface spi_burst_ctrl_if;
    import spi_burst_pkg::*;

    logic              I_wr_en;
    logic [DATA_W-1:0] I_wr_data;
    logic              O_tx_full;
    logic [LVL_W-1:0]  O_tx_level;
    logic              I_start;
    logic [LEN_W-1:0]  I_len;
    logic [1:0]        I_mode;
    logic              I_rx_keep;
    logic              O_busy;
    logic              O_done;
    logic              O_start_err;
    logic              O_timeout;
    logic              O_rx_ovf;
    logic              I_clr;
    logic              I_rd_en;
    logic [DATA_W-1:0] O_rd_data;
    logic              O_rx_empty;
    logic              O_spi_tx_en;
    logic              O_spi_rx_en;
    logic [DATA_W-1:0] O_spi_data;
    logic              O_spi_cpol;
    logic              O_spi_cpha;
    logic [DATA_W-1:0] I_spi_data;
    logic              I_spi_tx_done;
    logic              I_spi_rx_done;

    modport slave (
        input  I_wr_en, I_wr_data, I_start, I_len, I_mode, I_rx_keep, I_clr, I_rd_en,
        input  I_spi_data, I_spi_tx_done, I_spi_rx_done,
        output O_tx_full, O_tx_level, O_busy, O_done, O_start_err, O_timeout, O_rx_ovf,
        output O_rd_data, O_rx_empty, O_spi_tx_en, O_spi_rx_en, O_spi_data, O_spi_cpol, O_spi_cpha
    );

    modport master (
        output I_wr_en, I_wr_data, I_start, I_len, I_mode, I_rx_keep, I_clr, I_rd_en,
        output I_spi_data, I_spi_tx_done, I_spi_rx_done,
        input  O_tx_full, O_tx_level, O_busy, O_done, O_start_err, O_timeout, O_rx_ovf,
        input  O_rd_data, O_rx_empty, O_spi_tx_en, O_spi_rx_en, O_spi_data, O_spi_cpol, O_spi_cpha
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with flush, full/empty and occupancy
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_flush,
    input  logic             I_wr_en,
    input  logic [WIDTH-1:0] I_wr_data,
    input  logic             I_rd_en,
    output logic [WIDTH-1:0] O_rd_data,
    output logic             O_full,
    output logic             O_empty,
    output logic [LW-1:0]    O_level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_pop;
    logic             w_push;

    assign O_full  = (r_level == LW'(DEPTH));
    assign O_empty = (r_level == '0);
    assign O_level = r_level;
    // Masked so an empty FIFO presents zero rather than stale storage.
    assign O_rd_data = O_empty ? '0 : r_mem[r_rd_ptr];

    assign w_pop  = I_rd_en && !O_empty && !I_flush;
    assign w_push = I_wr_en && (!O_full || w_pop) && !I_flush;

    always_ff @(posedge I_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= I_wr_data;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst || I_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// rtl/spi_burst_ctrl.sv - burst sequencer feeding spi_whole from a TX FIFO and capturing into an RX FIFO
module spi_burst_ctrl
    import spi_burst_pkg::*;
#(
    parameter int TX_DEPTH = DEF_DEPTH,
    parameter int RX_DEPTH = DEF_DEPTH,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             I_clk,
    input  logic             I_rst,
    spi_burst_ctrl_if.slave  bus
);

    localparam int TX_LW = lvl_width(TX_DEPTH);
    localparam int RX_LW = lvl_width(RX_DEPTH);
    localparam int WD_W  = $clog2(TIMEOUT);

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_rx_keep;
    logic               r_cpol;
    logic               r_cpha;
    logic [DATA_W-1:0]  r_spi_data;
    logic               r_tx_en;
    logic [WD_W-1:0]    r_wd;
    logic               r_start_err;
    logic               r_timeout;
    logic               r_rx_ovf;

    logic               w_accept;
    logic               w_reject;
    logic               w_tx_pop;
    logic               w_tx_flush;
    logic               w_wd_trip;
    logic [DATA_W-1:0]  w_tx_head;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic [TX_LW-1:0]   w_tx_level;
    logic               w_rx_push;
    logic               w_rx_drop;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic [RX_LW-1:0]   w_rx_level;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH), .LW(TX_LW)) u_tx_fifo (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .I_flush   (w_tx_flush),
        .I_wr_en   (bus.I_wr_en),
        .I_wr_data (bus.I_wr_data),
        .I_rd_en   (w_tx_pop),
        .O_rd_data (w_tx_head),
        .O_full    (w_tx_full),
        .O_empty   (w_tx_empty),
        .O_level   (w_tx_level)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH), .LW(RX_LW)) u_rx_fifo (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .I_flush   (1'b0),
        .I_wr_en   (w_rx_push),
        .I_wr_data (bus.I_spi_data),
        .I_rd_en   (bus.I_rd_en),
        .O_rd_data (bus.O_rd_data),
        .O_full    (w_rx_full),
        .O_empty   (w_rx_empty),
        .O_level   (w_rx_level)
    );

    // Late rx_done (after tx_done) still lands while in DONE; only IDLE ignores it.
    assign w_rx_push = bus.I_spi_rx_done && r_rx_keep && (r_state != ST_IDLE);
    assign w_rx_drop = w_rx_push && w_rx_full && !(bus.I_rd_en && (w_rx_level != '0));

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_reject   = 1'b0;
        w_tx_pop   = 1'b0;
        w_tx_flush = 1'b0;
        w_wd_trip  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.I_start) begin
                    if (!w_tx_empty && (bus.I_len != '0) && (bus.I_len <= w_tx_level)) begin
                        w_accept = 1'b1;
                        w_next   = ST_LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                w_tx_pop = 1'b1;
                w_next   = ST_XFER;
            end
            ST_XFER: begin
                if (bus.I_spi_tx_done) begin
                    w_next = (r_remaining > LEN_W'(1)) ? ST_LOAD : ST_DONE;
                end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                    w_wd_trip = 1'b1;
                    w_next    = ST_ABORT;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            ST_ABORT: begin
                w_tx_flush = 1'b1;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_rx_keep   <= 1'b0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_spi_data  <= '0;
            r_tx_en     <= 1'b0;
            r_wd        <= '0;
            r_start_err <= 1'b0;
            r_timeout   <= 1'b0;
            r_rx_ovf    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_start_err <= w_reject;
            if (w_accept) begin
                r_remaining <= bus.I_len;
                r_rx_keep   <= bus.I_rx_keep;
                r_cpol      <= bus.I_mode[1];
                r_cpha      <= bus.I_mode[0];
            end
            if (r_state == ST_LOAD) begin
                r_spi_data <= w_tx_head;
                r_wd       <= '0;
            end else if (r_state == ST_XFER) begin
                r_wd <= r_wd + 1'b1;
            end
            if ((r_state == ST_XFER) && bus.I_spi_tx_done) begin
                r_remaining <= r_remaining - 1'b1;
            end
            // Held across the inter-byte LOAD so chip select stays asserted for the burst.
            r_tx_en   <= (w_next == ST_XFER) || ((w_next == ST_LOAD) && (r_state == ST_XFER));
            r_timeout <= w_wd_trip || (r_timeout && !bus.I_clr);
            r_rx_ovf  <= w_rx_drop || (r_rx_ovf && !bus.I_clr);
        end
    end

    assign bus.O_tx_full   = w_tx_full;
    assign bus.O_tx_level  = w_tx_level;
    assign bus.O_busy      = (r_state != ST_IDLE);
    assign bus.O_done      = (r_state == ST_DONE) || (r_state == ST_ABORT);
    assign bus.O_start_err = r_start_err;
    assign bus.O_timeout   = r_timeout;
    assign bus.O_rx_ovf    = r_rx_ovf;
    assign bus.O_rx_empty  = w_rx_empty;
    assign bus.O_spi_tx_en = r_tx_en;
    assign bus.O_spi_rx_en = r_tx_en && r_rx_keep;
    assign bus.O_spi_data  = r_spi_data;
    assign bus.O_spi_cpol  = r_cpol;
    assign bus.O_spi_cpha  = r_cpha;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb/tb_spi_burst_ctrl.sv - directed and randomized bench for spi_burst_ctrl with a queue-based reference model
module tb_spi_burst_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_burst_ctrl_if bus();

    spi_burst_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16), .TIMEOUT(16)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [1:0] mode_m = 2'b00;
    bit         ovf_m  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.I_wr_en = 0; bus.I_wr_data = 0; bus.I_start = 0; bus.I_len = 0;
        bus.I_mode = 0; bus.I_rx_keep = 0; bus.I_clr = 0; bus.I_rd_en = 0;
        bus.I_spi_data = 0; bus.I_spi_tx_done = 0; bus.I_spi_rx_done = 0;
    endtask

    task automatic model_reset();
        tx_q.delete(); rx_q.delete(); mode_m = 2'b00; ovf_m = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   bus.O_busy, 0);
        chk({tag, "_done"},   bus.O_done, 0);
        chk({tag, "_serr"},   bus.O_start_err, 0);
        chk({tag, "_tmo"},    bus.O_timeout, 0);
        chk({tag, "_ovf"},    bus.O_rx_ovf, 0);
        chk({tag, "_full"},   bus.O_tx_full, 0);
        chk({tag, "_level"},  bus.O_tx_level, 0);
        chk({tag, "_rxemp"},  bus.O_rx_empty, 1);
        chk({tag, "_rdata"},  bus.O_rd_data, 0);
        chk({tag, "_txen"},   bus.O_spi_tx_en, 0);
        chk({tag, "_rxen"},   bus.O_spi_rx_en, 0);
        chk({tag, "_sdata"},  bus.O_spi_data, 0);
        chk({tag, "_mode"},   {bus.O_spi_cpol, bus.O_spi_cpha}, 0);
    endtask

    task automatic wr(input logic [7:0] d);
        bus.I_wr_en = 1; bus.I_wr_data = d;
        tick();
        bus.I_wr_en = 0;
        if (tx_q.size() < 16) tx_q.push_back(d);
        chk("tx_level", bus.O_tx_level, tx_q.size());
        chk("tx_full", bus.O_tx_full, (tx_q.size() == 16));
    endtask

    task automatic start(input int len, input logic [1:0] mode, input bit keep);
        bit acc;
        acc = (len >= 1) && (len <= tx_q.size());
        bus.I_start = 1; bus.I_len = len[4:0]; bus.I_mode = mode; bus.I_rx_keep = keep;
        tick();
        bus.I_start = 0;
        chk("start_err", bus.O_start_err, !acc);
        chk("busy_after_start", bus.O_busy, acc);
        if (acc) mode_m = mode;
    endtask

    // Serves the SPI master side of an accepted burst; entered at the first LOAD cycle.
    task automatic run_bytes(input int len, input bit keep, input int bt_max, input bit loop,
                             input bit rd_last, input int abort_at, input bit wr_load,
                             input logic [7:0] wr_d);
        logic [7:0] exp;
        logic [7:0] miso;
        int bt;
        int bad;
        if (wr_load) begin bus.I_wr_en = 1; bus.I_wr_data = wr_d; end
        tick();
        bus.I_wr_en = 0;
        for (int k = 0; k < len; k++) begin
            exp = tx_q.pop_front();
            if (k == 0 && wr_load) tx_q.push_back(wr_d);
            if (k == abort_at) return;
            chk("mosi", bus.O_spi_data, exp);
            chk("tx_en_xfer", bus.O_spi_tx_en, 1);
            chk("rx_en_xfer", bus.O_spi_rx_en, keep);
            chk("mode_out", {bus.O_spi_cpol, bus.O_spi_cpha}, mode_m);
            bt  = $urandom_range(0, bt_max);
            bad = 0;
            repeat (bt) begin
                tick();
                if (bus.O_spi_data !== exp || bus.O_spi_tx_en !== 1'b1 || bus.O_done !== 1'b0) bad++;
            end
            chk("xfer_hold", bad, 0);
            miso = loop ? exp : 8'($urandom);
            bus.I_spi_tx_done = 1; bus.I_spi_rx_done = 1; bus.I_spi_data = miso;
            bus.I_rd_en = rd_last && (k == len - 1);
            if (bus.I_rd_en && rx_q.size() > 0) void'(rx_q.pop_front());
            if (keep) begin
                if (rx_q.size() < 16) rx_q.push_back(miso);
                else ovf_m = 1'b1;
            end
            tick();
            bus.I_spi_tx_done = 0; bus.I_spi_rx_done = 0; bus.I_rd_en = 0;
            if (k < len - 1) begin
                chk("tx_en_load", bus.O_spi_tx_en, 1);
                chk("no_done_mid", bus.O_done, 0);
                tick();
            end else begin
                chk("done_pulse", bus.O_done, 1);
                chk("tx_en_done", bus.O_spi_tx_en, 0);
                chk("rx_en_done", bus.O_spi_rx_en, 0);
                tick();
                chk("done_once", bus.O_done, 0);
                chk("idle_after", bus.O_busy, 0);
                chk("rx_ovf", bus.O_rx_ovf, ovf_m);
                chk("tx_level_after", bus.O_tx_level, tx_q.size());
            end
        end
    endtask

    task automatic drain();
        int n;
        n = rx_q.size();
        for (int i = 0; i < n; i++) begin
            chk("rx_nonempty", bus.O_rx_empty, 0);
            chk("rd_data", bus.O_rd_data, rx_q[0]);
            bus.I_rd_en = 1;
            tick();
            bus.I_rd_en = 0;
            void'(rx_q.pop_front());
        end
        chk("rx_empty", bus.O_rx_empty, 1);
        bus.I_rd_en = 1;
        tick();
        bus.I_rd_en = 0;
        chk("rd_empty_ignored", bus.O_rx_empty, 1);
        chk("rd_empty_data", bus.O_rd_data, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int len;
        int bad;
        idle_inputs();
        rst = 1;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 0;
        tick();

        // Basic loopback burst
        wr(8'h11); wr(8'h22); wr(8'h33);
        start(3, 2'b00, 1);
        run_bytes(3, 1, 4, 1, 0, -1, 0, 8'h00);
        drain();

        // Rejected starts
        wr(8'($urandom)); wr(8'($urandom));
        start(3, 2'b01, 0);
        tick();
        chk("start_err_one_cycle", bus.O_start_err, 0);
        chk("level_kept", bus.O_tx_level, 2);
        start(0, 2'b01, 0);

        // Mode latch survives I_mode changes mid-burst and between bursts
        start(2, 2'b11, 0);
        bus.I_mode = 2'b00;
        run_bytes(2, 0, 6, 0, 0, -1, 0, 8'h00);
        chk("mode_hold_after", {bus.O_spi_cpol, bus.O_spi_cpha}, 2'b11);
        chk("no_keep_rx_empty", bus.O_rx_empty, 1);

        // Randomized bursts
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) wr(8'($urandom));
            len = $urandom_range(1, tx_q.size());
            start(len, 2'($urandom), 1'($urandom));
            run_bytes(len, bus.I_rx_keep, 8, 1'($urandom), 0, -1, 0, 8'h00);
            drain();
        end

        // TX full, write+pop at full, RX overflow and same-cycle read
        while (tx_q.size() < 16) wr(8'($urandom));
        wr(8'hEE);
        start(16, 2'b10, 1);
        run_bytes(16, 1, 3, 1, 0, -1, 1, 8'hA5);
        start(1, 2'b10, 1);
        run_bytes(1, 1, 2, 1, 0, -1, 0, 8'h00);
        bus.I_clr = 1;
        tick();
        bus.I_clr = 0;
        ovf_m = 0;
        chk("ovf_cleared", bus.O_rx_ovf, 0);
        wr(8'h5C);
        start(1, 2'b10, 1);
        run_bytes(1, 1, 2, 1, 1, -1, 0, 8'h00);
        drain();

        // Watchdog abort
        wr(8'h01); wr(8'h02);
        start(2, 2'b01, 0);
        tick();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.O_spi_tx_en !== 1'b1) bad++;
            tick();
        end
        chk("wd_xfer_cycles", bad, 0);
        chk("abort_tx_en", bus.O_spi_tx_en, 0);
        chk("abort_timeout", bus.O_timeout, 1);
        chk("abort_done", bus.O_done, 1);
        tick();
        tx_q.delete();
        chk("abort_flush", bus.O_tx_level, 0);
        chk("abort_idle", bus.O_busy, 0);
        chk("abort_done_once", bus.O_done, 0);
        chk("timeout_sticky", bus.O_timeout, 1);
        bus.I_clr = 1;
        tick();
        bus.I_clr = 0;
        chk("timeout_cleared", bus.O_timeout, 0);

        // Reset during byte 2 of 4, then a normal burst
        for (int i = 0; i < 4; i++) wr(8'($urandom));
        start(4, 2'b11, 1);
        run_bytes(4, 1, 3, 1, 0, 1, 0, 8'h00);
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        chk_reset_outputs("midrst");
        tick();
        chk("midrst_no_done", bus.O_done, 0);
        wr(8'h44); wr(8'h55); wr(8'h66);
        start(3, 2'b01, 1);
        run_bytes(3, 1, 4, 1, 0, -1, 0, 8'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
